// File: rtl/ws2812b_pkg.sv
// Shared types and 50 MHz timing defaults for the WS2812B frame timer.
package ws2812b_pkg;

    localparam int BITS_PER_WORD    = 24;
    localparam int DEF_CLK_DIV_BIT  = 62;
    localparam int DEF_LATCH_CYCLES = 3000;
    localparam int DEF_LEN_W        = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BIT   = 2'd2,
        LATCH = 2'd3
    } state_t;

endpackage

// File: rtl/ws2812b_slot_counter.sv
// Modulo-MODULUS counter with a terminal-count flag; clr has priority over en.
module ws2812b_slot_counter #(
    parameter int MODULUS = 2,
    parameter int W       = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    assign tc = (count == LAST);

    // Count register: wraps to zero after the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : (count + ONE);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/ws2812b_frame_timer.sv
// Bit-slot / word-load trigger generator for the WS2812B transmitter.
// Optional build macro WS2812B_AUTO_REFRESH_EN repeats frames while start is held.
module ws2812b_frame_timer
    import ws2812b_pkg::*;
#(
    parameter int CLK_DIV_BIT  = DEF_CLK_DIV_BIT,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int LEN_W        = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    output logic             btrig,
    output logic             wtrig,
    output logic             busy,
    output logic             frame_done,
    output logic [LEN_W-1:0] word_idx
);

    localparam int DIV_W = $clog2(CLK_DIV_BIT);
    localparam int BIT_W = $clog2(BITS_PER_WORD);
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV_BIT - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [LAT_W-1:0] LAT_PRE  = LAT_W'((LATCH_CYCLES > 1) ? (LATCH_CYCLES - 2) : 0);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic             LAT_ONE  = (LATCH_CYCLES == 1);

    state_t             state_r;
    logic [BIT_W-1:0]   bit_r;
    logic [LEN_W-1:0]   len_r;
    logic [DIV_W-1:0]   div_count_s;
    logic               div_tc_s;
    logic [LAT_W-1:0]   lat_count_s;
    logic               lat_tc_s;
    logic               div_run_s;
    logic               lat_run_s;
`ifdef WS2812B_AUTO_REFRESH_EN
    logic               stop_r;
`endif

    assign div_run_s = (state_r == BIT);
    assign lat_run_s = (state_r == LATCH);

    ws2812b_slot_counter #(
        .MODULUS (CLK_DIV_BIT),
        .W       (DIV_W)
    ) u_div (
        .clk   (clk),
        .rst   (reset),
        .clr   (!div_run_s),
        .en    (div_run_s),
        .count (div_count_s),
        .tc    (div_tc_s)
    );

    ws2812b_slot_counter #(
        .MODULUS (LATCH_CYCLES),
        .W       (LAT_W)
    ) u_latch (
        .clk   (clk),
        .rst   (reset),
        .clr   (!lat_run_s),
        .en    (lat_run_s),
        .count (lat_count_s),
        .tc    (lat_tc_s)
    );

    // Frame FSM; every output is registered from the state of the coming clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            bit_r      <= '0;
            len_r      <= '0;
            btrig      <= 1'b0;
            wtrig      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            word_idx   <= '0;
`ifdef WS2812B_AUTO_REFRESH_EN
            stop_r     <= 1'b0;
`endif
        end else begin
            btrig      <= 1'b0;
            wtrig      <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    word_idx <= '0;
                    if (start && (frame_len != '0)) begin
                        len_r   <= frame_len;
                        state_r <= LOAD;
                        wtrig   <= 1'b1;
                        busy    <= 1'b1;
`ifdef WS2812B_AUTO_REFRESH_EN
                        stop_r  <= 1'b0;
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    bit_r <= '0;
                    if (abort) begin
                        state_r    <= LATCH;
                        frame_done <= LAT_ONE;
`ifdef WS2812B_AUTO_REFRESH_EN
                        stop_r     <= 1'b1;
`endif
                    end else begin
                        state_r <= BIT;
                        btrig   <= 1'b1;
                    end
                end
                BIT: begin
                    if (abort) begin
                        state_r    <= LATCH;
                        frame_done <= LAT_ONE;
`ifdef WS2812B_AUTO_REFRESH_EN
                        stop_r     <= 1'b1;
`endif
                    end else if (div_tc_s) begin
                        // wtrig high now means this clock is a word boundary, not the frame end.
                        if (bit_r != BIT_LAST) begin
                            bit_r <= bit_r + BIT_ONE;
                            btrig <= 1'b1;
                        end else if (wtrig) begin
                            bit_r <= '0;
                            btrig <= 1'b1;
                        end else begin
                            state_r    <= LATCH;
                            frame_done <= LAT_ONE;
                        end
                    end else if ((div_count_s == DIV_PRE) && (bit_r == BIT_LAST) &&
                                 (word_idx != (len_r - LEN_ONE))) begin
                        wtrig    <= 1'b1;
                        word_idx <= word_idx + LEN_ONE;
                    end
                end
                LATCH: begin
                    frame_done <= (lat_count_s == LAT_PRE) && !lat_tc_s;
`ifdef WS2812B_AUTO_REFRESH_EN
                    if (abort) begin
                        stop_r <= 1'b1;
                    end
                    if (lat_tc_s) begin
                        word_idx <= '0;
                        if (start && !stop_r && !abort) begin
                            state_r <= LOAD;
                            wtrig   <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
`else
                    if (lat_tc_s) begin
                        word_idx <= '0;
                        state_r  <= IDLE;
                        busy     <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                    word_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/ws2812b_frame_timer.md
Name: ws2812b_frame_timer

Overview:
- Upstream timing stage for the WS2812B FIFO transmitter.
- Generates the per-bit slot trigger (btrig) and the per-word load trigger (wtrig) that drive the FIFO pop, the shift buffer and the line encoder.
- Frames a burst of N 24-bit LED words, then enforces the WS2812B latch/reset gap.
- Started by the Avalon control logic through a start/busy handshake.

Parameters:
- CLK_DIV_BIT, 62, clocks per bit slot (1.24 us at 50 MHz); must be >= 2.
- BITS_PER_WORD, 24, bits per LED word.
- LATCH_CYCLES, 3000, idle clocks after the last slot (60 us at 50 MHz); must be >= 1.
- LEN_W, 10, width of the frame length and word index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a frame; sampled only in IDLE.
- frame_len  in  LEN_W  number of words in the frame; captured on an accepted start.
- abort  in  1  terminate the frame early.
- btrig  out  1  one-clock pulse on the first clock of each bit slot.
- wtrig  out  1  one-clock pulse exactly one clock before bit 0 of each word (FIFO pop and buffer load).
- busy  out  1  frame in progress, including the latch gap.
- frame_done  out  1  one-clock pulse on the final latch clock.
- word_idx  out  LEN_W  index of the word currently being sent; 0 in IDLE.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, also mid-frame):
  - state returns to IDLE;
  - btrig, wtrig, busy, frame_done and word_idx all 0;
  - all internal counters cleared.
- All outputs are registered.
- States: IDLE, LOAD, BIT, LATCH.
- IDLE:
  - start=1 with frame_len!=0: capture frame_len and go to LOAD.
  - start with frame_len==0: ignored; busy stays 0.
- LOAD (one clock): wtrig=1, busy=1. Next state BIT with div=0, bit=0.
- BIT:
  - div counts 0..CLK_DIV_BIT-1; btrig=1 when div==0.
  - Last clock of a slot (div==CLK_DIV_BIT-1):
    - bit<BITS_PER_WORD-1: bit+1.
    - bit==BITS_PER_WORD-1 and word_idx<len-1: wtrig=1 on this same clock, word_idx+1, bit=0. No extra clock is inserted, so the btrig period is exactly CLK_DIV_BIT across word boundaries.
    - bit==BITS_PER_WORD-1 and word_idx==len-1: go to LATCH.
- LATCH:
  - Counts LATCH_CYCLES clocks; btrig and wtrig stay 0.
  - frame_done=1 on the last latch clock.
  - Next state IDLE; busy=0 from the following clock.
- start while busy: ignored; no queueing.
- abort:
  - In LOAD or BIT: next clock enters LATCH. No further btrig or wtrig; the full latch gap runs and frame_done still pulses.
  - In IDLE or LATCH: ignored.
  - start and abort together in IDLE: the start is accepted.
- Latency: start clock = 0, first wtrig at clock 1, first btrig at clock 2.
- Counter widths: div is clog2(CLK_DIV_BIT); bit is clog2(BITS_PER_WORD); latch counter is clog2(LATCH_CYCLES). No wrap-around is possible within legal parameters.

Optional Feature:
- Macro: WS2812B_AUTO_REFRESH_EN.
- Defined:
  - After LATCH ends, return to LOAD (not IDLE) using the captured length, so frames repeat indefinitely.
  - frame_done still pulses once per frame; busy stays 1.
  - abort during LATCH, or a low start sampled on the last latch clock, returns to IDLE after the gap.
- Undefined: single-shot behaviour as described above; that logic is not present.

Decomposition:
- Package ws2812b_pkg holds:
  - the state enum (IDLE, LOAD, BIT, LATCH);
  - BITS_PER_WORD;
  - default timing constants for 50 MHz (CLK_DIV_BIT=62, LATCH_CYCLES=3000).
- One natural sub-module: ws2812b_slot_counter, a parameterised modulo counter with a terminal-count flag. It is instantiated for the div counter and for the latch counter.

Test Plan (CLK_DIV_BIT=4, LATCH_CYCLES=10, start at clock 0):
- len=1 -> wtrig at clock 1; 24 btrig at clocks 2,6,...,94; no activity at 95..107; frame_done at 107; busy high 1..107, low at 108.
- len=3 -> wtrig at clocks 1, 97, 193; 72 btrig with constant spacing 4; word_idx steps 0->1 at 97 and 1->2 at 193; frame_done at 299.
- start pulsed at clock 40 of a len=2 frame, then start with frame_len=0 in IDLE -> both ignored; the first frame's timing is unchanged; busy stays 0 after the second start.
- abort at clock 50 of a len=2 frame -> no btrig or wtrig after clock 50; frame_done at clock 60; busy low at 61.
- reset asserted asynchronously mid-BIT at clock 30 -> all outputs 0 before the next clock edge; after release, start with len=1 reproduces scenario 1 timing.
- With WS2812B_AUTO_REFRESH_EN, len=1 -> second wtrig at clock 108, frame_done at 107 and 214; abort at clock 150 -> IDLE after the gap, busy low.
